reg_load_arbiter: RTL and testbench

Shares one W-bit parallel-load register among N requesters using round-robin arbitration. Each grant loads the winner's data word into the register and acknowledges it for one cycle. The register is then held stable for a programmable hold window before the next grant. The block sits between the requesting blocks and the shared register; the register is instantiated inside this block.

---
 rtl/reg_load_arbiter_pkg.sv | 15 +
 rtl/par_load_reg.sv | 25 ++
 rtl/reg_load_arbiter.sv | 98 +++++++++
 tb/tb_reg_load_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_load_arbiter_pkg.sv
// Shared types and helpers for the round-robin register-load arbiter.
package reg_load_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int MAX_REQ = 32;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/par_load_reg.sv
// W-bit parallel-load register; clear takes priority over load.
module par_load_reg
    import reg_load_arbiter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter granting N requesters access to one shared load register,
// holding the register stable for HOLD_CYCLES after each load.
//   state | meaning
//   IDLE  | waiting for a request; grants at the first edge with req!=0 and clr=0
//   HOLD  | register held for HOLD_CYCLES cycles; requests ignored
module reg_load_arbiter
    import reg_load_arbiter_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         data,
    input  logic                   clr,
    output logic [N-1:0]           ack,
    output logic [W-1:0]           A,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   load_o,
    output logic                   busy
);

    localparam int PTR_W = $clog2(N);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [W-1:0]       grant_data;
    logic               do_grant;

    // Scan from the farthest offset down so the requester nearest the pointer wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'((int'(ptr) + k) % N);
                grant_data  = data[((int'(ptr) + k) % N) * W +: W];
            end
        end
    end

    assign do_grant = (state == IDLE) && !clr && grant_valid;

    par_load_reg #(.W(W)) u_reg (
        .clk  (clk),
        .rst  (rst),
        .load (do_grant),
        .clr  (clr),
        .d    (grant_data),
        .q    (A)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            owner  <= '0;
            ack    <= '0;
            load_o <= 1'b0;
            busy   <= 1'b0;
        end else begin
            ack    <= '0;
            load_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_grant) begin
                        owner  <= grant_idx;
                        ack    <= N'(onehot(32'(grant_idx)));
                        load_o <= 1'b1;
                        ptr    <= PTR_W'((int'(grant_idx) + 1) % N);
                        cnt    <= CNT_W'(HOLD_CYCLES - 1);
                        busy   <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter: grants are predicted into a scoreboard
// when requests are driven and matched when load_o pulses.
module tb_reg_load_arbiter;

    localparam int N = 4;
    localparam int W = 4;
    localparam int H = 2;

    typedef struct {
        int         cyc;
        logic [3:0] ack;
        logic [3:0] a;
        logic [1:0] owner;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic           clr;
    logic [N-1:0]   ack;
    logic [W-1:0]   A;
    logic [1:0]     owner;
    logic           load_o;
    logic           busy;

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    reg_load_arbiter #(.N(N), .W(W), .HOLD_CYCLES(H)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data   (data),
        .clr    (clr),
        .ack    (ack),
        .A      (A),
        .owner  (owner),
        .load_o (load_o),
        .busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input int at_cyc, input logic [3:0] a, input logic [1:0] o);
        exp_t e;
        e.cyc   = at_cyc;
        e.ack   = 4'b0001 << o;
        e.a     = a;
        e.owner = o;
        q.push_back(e);
    endtask

    task automatic check_cycle();
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missed_grant", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (load_o === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_grant", ack, 0);
            end else begin
                e = q.pop_front();
                chk("grant_cycle", cyc, e.cyc);
                chk("grant_ack", ack, e.ack);
                chk("grant_A", A, e.a);
                chk("grant_owner", owner, e.owner);
            end
        end else begin
            chk("ack_without_load", ack, 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0) break;
            step();
        end
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        rst  = 1'b0;
        req  = '0;
        data = '0;
        clr  = 1'b0;

        // power-on reset values
        step();
        step();
        chk("rst_A", A, 0);
        chk("rst_ack", ack, 0);
        chk("rst_owner", owner, 0);
        chk("rst_load", load_o, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        // single request to index 2, busy for exactly H cycles
        req  = 4'b0100;
        data = 16'h0A00;
        expect_grant(cyc + 1, 4'hA, 2'd2);
        step();
        chk("single_busy1", busy, 1);
        req = '0;
        step();
        chk("single_busy2", busy, 1);
        chk("single_load_low", load_o, 0);
        chk("single_A_held", A, 4'hA);
        step();
        chk("single_busy_end", busy, 0);

        // wrap-around from pointer 3 with req 1001 held
        req  = 4'b1001;
        data = 16'h9008;
        expect_grant(cyc + 1, 4'h9, 2'd3);
        expect_grant(cyc + 4, 4'h8, 2'd0);
        expect_grant(cyc + 7, 4'h9, 2'd3);
        drain(12);
        req = '0;
        step();
        step();

        // clr collides with a pending request in IDLE
        req  = 4'b0001;
        data = 16'h0005;
        clr  = 1'b1;
        step();
        chk("clr_coll_A", A, 0);
        chk("clr_coll_load", load_o, 0);
        clr = 1'b0;
        expect_grant(cyc + 1, 4'h5, 2'd0);
        drain(4);
        req = '0;
        step();
        step();

        // clr inside HOLD; a request raised and withdrawn during HOLD is never acked
        req  = 4'b0010;
        data = 16'h0070;
        expect_grant(cyc + 1, 4'h7, 2'd1);
        step();
        req = 4'b1000;
        clr = 1'b1;
        step();
        chk("hold_clr_A", A, 0);
        chk("hold_clr_busy", busy, 1);
        chk("hold_clr_owner", owner, 1);
        clr = 1'b0;
        req = '0;
        step();
        chk("hold_end_busy", busy, 0);
        step();
        step();

        // asynchronous reset while ack=0010 is on the outputs
        req  = 4'b0010;
        data = 16'h00B0;
        expect_grant(cyc + 1, 4'hB, 2'd1);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_ack", ack, 0);
        chk("async_rst_A", A, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_load", load_o, 0);
        chk("async_rst_owner", owner, 0);
        req = '0;
        #1;
        rst = 1'b1;

        // round robin with all four requesting; pointer restarts at 0
        req  = 4'b1111;
        data = 16'h3210;
        expect_grant(cyc + 1,  4'h0, 2'd0);
        expect_grant(cyc + 4,  4'h1, 2'd1);
        expect_grant(cyc + 7,  4'h2, 2'd2);
        expect_grant(cyc + 10, 4'h3, 2'd3);
        expect_grant(cyc + 13, 4'h0, 2'd0);
        drain(20);
        req = '0;
        step();
        step();

        // lone requester held high is regranted every H+1 edges
        req  = 4'b0100;
        data = 16'h0C00;
        expect_grant(cyc + 1, 4'hC, 2'd2);
        expect_grant(cyc + 4, 4'hC, 2'd2);
        drain(8);
        req = '0;
        step();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
